// File: rtl/isqrt_pkg.sv
// Shared types and width helpers for the sequential integer square-root engine.
package isqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ISQRT_W_DEFAULT = 16;
  localparam int ROOT_W          = ISQRT_W_DEFAULT / 2;
  localparam int REM_W           = ISQRT_W_DEFAULT / 2 + 1;

  function automatic int root_w(input int width);
    return width / 2;
  endfunction

  function automatic int rem_w(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring square-root iteration: shift in the next radicand bit pair,
// try subtracting (4q+1) and append the resulting root bit.
module isqrt_step
  import isqrt_pkg::*;
#(
  parameter int WIDTH = ISQRT_W_DEFAULT
) (
  input  logic [WIDTH/2+1:0] r,
  input  logic [WIDTH/2-1:0] q,
  input  logic [1:0]         pair,
  output logic [WIDTH/2+1:0] r_next,
  output logic [WIDTH/2-1:0] q_next
);

  localparam int RW = root_w(WIDTH);
  localparam int PW = WIDTH / 2 + 2;

  logic [PW-1:0] shifted_s;
  logic [PW-1:0] trial_s;

  // Trial subtraction; the partial remainder never exceeds PW bits by construction.
  always_comb begin
    shifted_s = (r << 2) | {{(PW-2){1'b0}}, pair};
    trial_s   = ({2'b00, q} << 2) | {{(PW-1){1'b0}}, 1'b1};
    if (shifted_s >= trial_s) begin
      r_next = shifted_s - trial_s;
      q_next = (q << 1) | {{(RW-1){1'b0}}, 1'b1};
    end else begin
      r_next = shifted_s;
      q_next = q << 1;
    end
  end

endmodule

// File: rtl/isqrt_iter.sv
// Sequential integer square root, one root bit per clock (restoring algorithm).
// Optional round-to-nearest output root_rnd is enabled by defining ISQRT_ROUND_EN.
module isqrt_iter
  import isqrt_pkg::*;
#(
  parameter int WIDTH = ISQRT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   radicand,
  output logic               busy,
  output logic               done,
  output logic [WIDTH/2-1:0] root,
  output logic [WIDTH/2:0]   rem
`ifdef ISQRT_ROUND_EN
  ,
  output logic [WIDTH/2-1:0] root_rnd
`endif
);

  localparam int RW   = root_w(WIDTH);
  localparam int REMW = rem_w(WIDTH);
  localparam int PW   = WIDTH / 2 + 2;
  localparam int CW   = $clog2(RW + 1);

  state_t          state_r;
  state_t          state_s;
  logic [CW-1:0]   cnt_r;
  logic [WIDTH-1:0] rad_r;
  logic [PW-1:0]   r_r;
  logic [RW-1:0]   q_r;
  logic [PW-1:0]   r_next_s;
  logic [RW-1:0]   q_next_s;
  logic            accept_s;
  logic            last_s;

  assign accept_s = start && ((state_r == IDLE) || (state_r == DONE));
  assign last_s   = (state_r == CALC) && (cnt_r == CW'(1));

  isqrt_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_r),
    .q      (q_r),
    .pair   (rad_r[WIDTH-1:WIDTH-2]),
    .r_next (r_next_s),
    .q_next (q_next_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; DONE accepts a new start just like IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = CALC;
        else       state_s = IDLE;
      end
      CALC: begin
        if (cnt_r == CW'(1)) state_s = DONE;
        else                 state_s = CALC;
      end
      DONE: begin
        if (start) state_s = CALC;
        else       state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

`ifdef ISQRT_ROUND_EN
  logic [RW-1:0] rnd_s;

  // Round to nearest, saturating when the root is already all-ones.
  always_comb begin
    if (({1'b0, q_next_s} < r_next_s[REMW-1:0]) && (q_next_s != {RW{1'b1}})) begin
      rnd_s = q_next_s + RW'(1);
    end else begin
      rnd_s = q_next_s;
    end
  end
`endif

  // Datapath and registered outputs; root/rem only move on the final iteration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      root  <= '0;
      rem   <= '0;
      cnt_r <= '0;
      rad_r <= '0;
      r_r   <= '0;
      q_r   <= '0;
`ifdef ISQRT_ROUND_EN
      root_rnd <= '0;
`endif
    end else begin
      busy <= (state_s == CALC);
      done <= (state_s == DONE);
      if (accept_s) begin
        rad_r <= radicand;
        r_r   <= '0;
        q_r   <= '0;
        cnt_r <= CW'(RW);
      end else if (state_r == CALC) begin
        rad_r <= {rad_r[WIDTH-3:0], 2'b00};
        r_r   <= r_next_s;
        q_r   <= q_next_s;
        cnt_r <= cnt_r - CW'(1);
        if (last_s) begin
          root <= q_next_s;
          rem  <= r_next_s[REMW-1:0];
`ifdef ISQRT_ROUND_EN
          root_rnd <= rnd_s;
`endif
        end
      end
    end
  end

endmodule
